// File: rtl/camara_ctrl.sv
// camara_ctrl: capture sequencer between the camera front end and the
// frame-buffer RAM. It arms on a frame boundary (VSYNC high), converts RGB565
// pixels to RGB332 and writes them to sequential addresses. It closes each
// frame on frame_done and flags frames whose pixel count is wrong.
module camara_ctrl #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              p_clock,
  input  logic              rst,
  input  logic              vsync,
  input  logic              start,
  input  logic              continuous,
  input  logic              pixel_valid,
  input  logic [15:0]       pixel_data,
  input  logic              frame_done,
  output logic              lect,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);

  // Expected pixels per frame, and the saturation point one above it.
  // Saturating there keeps long frames distinguishable without ever wrapping.
  localparam logic [ADDR_W:0] PIX_TOTAL = (ADDR_W+1)'(H_RES * V_RES);
  localparam logic [ADDR_W:0] PIX_SAT   = (ADDR_W+1)'(H_RES * V_RES + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t            state_r;
  logic [ADDR_W:0]   count_r;
  logic              active_r;

  logic              pix_take_s;
  logic              pix_inc_s;
  logic              pix_write_s;
  logic [ADDR_W:0]   count_next_s;

  // RGB565 -> RGB332: keep the top bits of each colour channel.
  function automatic logic [7:0] rgb565_to_332(input logic [15:0] px);
    return {px[15:13], px[10:8], px[4:3]};
  endfunction

  // Pixel acceptance and next counter value. This also feeds frame_err, so a
  // pixel arriving together with frame_done is counted.
  always_comb begin
    pix_take_s   = 1'b0;
    pix_inc_s    = 1'b0;
    pix_write_s  = 1'b0;
    count_next_s = count_r;
    if (state_r == ST_CAPTURE) begin
      pix_take_s = pixel_valid;
    end else begin
      pix_take_s = 1'b0;
    end
    if (pix_take_s) begin
      pix_write_s = (count_r < PIX_TOTAL);
      pix_inc_s   = (count_r != PIX_SAT);
    end else begin
      pix_write_s = 1'b0;
      pix_inc_s   = 1'b0;
    end
    count_next_s = count_r + {{ADDR_W{1'b0}}, pix_inc_s};
  end

  // Sequencer FSM with registered outputs and the frame-buffer write port.
  always_ff @(posedge p_clock or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      count_r   <= '0;
      active_r  <= 1'b0;
      lect      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= 8'h00;
    end else begin
      mem_we <= pix_write_s;
      if (pix_write_s) begin
        mem_addr <= count_r[ADDR_W-1:0];
        mem_data <= rgb565_to_332(pixel_data);
      end else begin
        mem_addr <= mem_addr;
        mem_data <= mem_data;
      end
      done <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          lect <= 1'b0;
          if (start) begin
            state_r   <= ST_ARM;
            busy      <= 1'b1;
            frame_err <= 1'b0;
            count_r   <= '0;
            active_r  <= 1'b0;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_ARM: begin
          busy <= 1'b1;
          if (vsync) begin
            state_r <= ST_CAPTURE;
            lect    <= 1'b1;
          end else begin
            lect <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          busy    <= 1'b1;
          lect    <= 1'b1;
          count_r <= count_next_s;
          if (!vsync) begin
            active_r <= 1'b1;
          end else begin
            active_r <= active_r;
          end
          // A frame_done left over from the previous frame is ignored until
          // VSYNC has fallen at least once inside this capture.
          if (frame_done && active_r) begin
            state_r   <= ST_DONE;
            done      <= 1'b1;
            frame_err <= (count_next_s != PIX_TOTAL);
          end else begin
            state_r <= ST_CAPTURE;
          end
        end
        ST_DONE: begin
          lect     <= 1'b0;
          count_r  <= '0;
          active_r <= 1'b0;
          if (continuous) begin
            state_r <= ST_ARM;
            busy    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          lect     <= 1'b0;
          busy     <= 1'b0;
          count_r  <= '0;
          active_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_camara_ctrl.sv
// Testbench for camara_ctrl on a 4x2 frame. A monitor records every
// frame-buffer write. Each frame is then compared against a model built from
// the random pixel list: the first min(n, 8) pixels go to addresses 0.. with
// arithmetic RGB565->RGB332 conversion, one done pulse is expected, and
// frame_err is set when n != 8.
module tb_camara_ctrl;
  localparam int H   = 4;
  localparam int V   = 2;
  localparam int AW  = 4;
  localparam int TOT = H * V;

  logic          p_clock = 1'b0;
  logic          rst;
  logic          vsync, start, continuous, pixel_valid, frame_done;
  logic [15:0]   pixel_data;
  logic          lect, mem_we, busy, done, frame_err;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [AW-1:0] wq_addr[$];
  logic [7:0]    wq_data[$];
  logic [7:0]    last_data[$];

  camara_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .p_clock(p_clock), .rst(rst), .vsync(vsync), .start(start),
    .continuous(continuous), .pixel_valid(pixel_valid),
    .pixel_data(pixel_data), .frame_done(frame_done), .lect(lect),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .busy(busy), .done(done), .frame_err(frame_err)
  );

  always #5 p_clock = ~p_clock;

  // write / done monitor, sampled on the falling edge
  always @(negedge p_clock) begin
    if (!rst) begin
      if (mem_we) begin
        wq_addr.push_back(mem_addr);
        wq_data.push_back(mem_data);
      end
      if (done) done_cnt++;
    end
  end

  function automatic logic [7:0] ref_conv(input logic [15:0] px);
    int r, g, b;
    r = int'(px[15:11]) / 4;
    g = int'(px[10:5]) / 8;
    b = int'(px[4:0]) / 8;
    return 8'(r * 32 + g * 4 + b);
  endfunction

  task automatic cyc();
    @(posedge p_clock);
    #1;
  endtask

  task automatic start_capture(input string tag);
    start = 1'b1;
    cyc();
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s start_busy: got %b want 1", tag, busy); end
  endtask

  // Drives one frame from the vsync-high prelude to the cycle after DONE.
  task automatic do_frame(input int n, input int max_gap, input bit stale_fd,
                          input bit fd_with_last, input bit fixed2,
                          input bit cont_next, input string tag);
    logic [15:0] px[$];
    logic [15:0] p;
    int d0;
    int exp_w;
    d0 = done_cnt;
    vsync = 1'b1;
    frame_done = stale_fd;
    repeat (3) cyc();
    total++;
    if (lect !== 1'b1) begin bad++; $display("FAIL %s lect_capture: got %b want 1", tag, lect); end
    total++;
    if (done_cnt != d0) begin bad++; $display("FAIL %s early_done: got %0d want 0", tag, done_cnt - d0); end
    vsync = 1'b0;
    frame_done = 1'b0;
    continuous = cont_next;
    cyc();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(max_gap, 0)) cyc();
      p = 16'($urandom);
      if (fixed2 && i == 0) p = 16'hF81F;
      if (fixed2 && i == 1) p = 16'h07E0;
      px.push_back(p);
      pixel_valid = 1'b1;
      pixel_data  = p;
      if (fd_with_last && i == n - 1) begin
        vsync = 1'b1;
        frame_done = 1'b1;
      end
      cyc();
      pixel_valid = 1'b0;
    end
    if (!fd_with_last) begin
      cyc();
      vsync = 1'b1;
      frame_done = 1'b1;
      cyc();
    end
    // now in the DONE cycle
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL %s done_pulse: got %b want 1", tag, done); end
    total++;
    if (frame_err !== (n != TOT)) begin bad++; $display("FAIL %s frame_err: got %b want %b", tag, frame_err, (n != TOT)); end
    total++;
    if (lect !== 1'b1) begin bad++; $display("FAIL %s lect_in_done: got %b want 1", tag, lect); end
    frame_done = 1'b0;
    cyc();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL %s done_width: got %b want 0", tag, done); end
    total++;
    if (busy !== cont_next) begin bad++; $display("FAIL %s busy_after: got %b want %b", tag, busy, cont_next); end
    total++;
    if (lect !== 1'b0) begin bad++; $display("FAIL %s lect_after: got %b want 0", tag, lect); end
    total++;
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL %s done_count: got %0d want 1", tag, done_cnt - d0); end
    exp_w = (n < TOT) ? n : TOT;
    total++;
    if (wq_addr.size() != exp_w) begin bad++; $display("FAIL %s write_count: got %0d want %0d", tag, wq_addr.size(), exp_w); end
    for (int i = 0; i < exp_w && i < wq_addr.size(); i++) begin
      total++;
      if (wq_addr[i] !== AW'(i)) begin bad++; $display("FAIL %s addr[%0d]: got %0d want %0d", tag, i, wq_addr[i], i); end
      total++;
      if (wq_data[i] !== ref_conv(px[i])) begin bad++; $display("FAIL %s data[%0d]: got %h want %h", tag, i, wq_data[i], ref_conv(px[i])); end
    end
    last_data = wq_data;
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; vsync = 1'b0; start = 1'b0; continuous = 1'b0;
    pixel_valid = 1'b0; pixel_data = 16'h0000; frame_done = 1'b0;
    #1;
    total++;
    if ({lect, mem_we, busy, done, frame_err} !== 5'b00000 || mem_addr !== '0 || mem_data !== 8'h00) begin
      bad++; $display("FAIL reset_outputs: got %b/%h/%h want 0", {lect, mem_we, busy, done, frame_err}, mem_addr, mem_data);
    end
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    start_capture("single");
    do_frame(8, 1, 1'b0, 1'b0, 1'b0, 1'b0, "single");
  endtask

  task automatic test_color();
    start_capture("color");
    do_frame(8, 1, 1'b0, 1'b0, 1'b1, 1'b0, "color");
    total++;
    if (last_data.size() < 2 || last_data[0] !== 8'hE3) begin bad++; $display("FAIL color_F81F: want e3"); end
    total++;
    if (last_data.size() < 2 || last_data[1] !== 8'h1C) begin bad++; $display("FAIL color_07E0: want 1c"); end
  endtask

  task automatic test_long();
    start_capture("long");
    do_frame(10, 1, 1'b0, 1'b0, 1'b0, 1'b0, "long");
  endtask

  task automatic test_arm_wait();
    vsync = 1'b0;
    start_capture("armwait");
    total++;
    if (frame_err !== 1'b0) begin bad++; $display("FAIL armwait_err_clear: got %b want 0", frame_err); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++;
      if (lect !== 1'b0) begin bad++; $display("FAIL armwait_lect[%0d]: got %b want 0", i, lect); end
    end
    do_frame(8, 1, 1'b1, 1'b0, 1'b0, 1'b0, "armwait");
  endtask

  task automatic test_short();
    start_capture("short");
    do_frame(5, 1, 1'b0, 1'b0, 1'b0, 1'b0, "short");
  endtask

  task automatic test_back_to_back();
    start_capture("b2b");
    do_frame(8, 0, 1'b0, 1'b1, 1'b0, 1'b0, "b2b");
  endtask

  task automatic test_continuous();
    continuous = 1'b1;
    start_capture("cont");
    do_frame(8, 1, 1'b0, 1'b0, 1'b0, 1'b1, "cont1");
    do_frame(8, 1, 1'b0, 1'b0, 1'b0, 1'b1, "cont2");
    do_frame(8, 1, 1'b0, 1'b0, 1'b0, 1'b0, "cont3");
    cyc();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL cont_stop_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    start_capture("rstmid");
    vsync = 1'b1;
    repeat (3) cyc();
    vsync = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      pixel_valid = 1'b1; pixel_data = 16'($urandom);
      cyc();
      pixel_valid = 1'b0;
      cyc();
    end
    pixel_valid = 1'b1; pixel_data = 16'($urandom);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({lect, mem_we, busy, done, frame_err} !== 5'b00000 || mem_addr !== '0 || mem_data !== 8'h00) begin
      bad++; $display("FAIL rstmid_outputs: got %b/%h/%h want 0", {lect, mem_we, busy, done, frame_err}, mem_addr, mem_data);
    end
    pixel_valid = 1'b0;
    cyc();
    rst = 1'b0;
    wq_addr.delete();
    wq_data.delete();
    cyc();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle: got %b want 0", busy); end
    start_capture("rstmid_clean");
    do_frame(8, 1, 1'b0, 1'b0, 1'b0, 1'b0, "rstmid_clean");
  endtask

  initial begin
    test_reset();
    test_single();
    test_color();
    test_long();
    test_arm_wait();
    test_short();
    test_back_to_back();
    test_continuous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/camara_ctrl.md
# camara_ctrl

Capture sequencer between the OV-series camera front end and the frame-buffer RAM. On a start request it waits for a frame boundary and enables the capture front end (`lect`) only while VSYNC is high, so the front end always starts at the top of a frame. It then converts each RGB565 pixel to RGB332, writes it to sequential frame-buffer addresses, and closes the frame on `frame_done`. It supports single-shot and continuous modes and reports short, long and overflow frames.

## Interface
Parameters:
- `H_RES`, 160, active pixels per line.
- `V_RES`, 120, active lines per frame.
- `ADDR_W`, 15, frame-buffer address width; must satisfy 2^ADDR_W ≥ H_RES*V_RES.

Ports:
- `p_clock`  in  1  pixel clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `vsync`  in  1  camera VSYNC, already synchronous to `p_clock`; high = vertical blanking.
- `start`  in  1  capture request, level; sampled only in IDLE.
- `continuous`  in  1  1 = re-arm after each frame; sampled at DONE.
- `pixel_valid`  in  1  front-end pixel strobe.
- `pixel_data`  in  16  front-end RGB565 pixel.
- `frame_done`  in  1  front-end end-of-frame flag.
- `lect`  out  1  front-end capture enable.
- `mem_addr`  out  ADDR_W  frame-buffer write address.
- `mem_data`  out  8  RGB332 write data.
- `mem_we`  out  1  frame-buffer write enable, one cycle per pixel.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse per completed frame.
- `frame_err`  out  1  sticky: last frame's pixel count ≠ H_RES*V_RES.

## Operation
- States: IDLE, ARM, CAPTURE, DONE. Encoding is free.
- IDLE:
  - `lect`=0.
  - `start`=1 → ARM; clears `frame_err`, the pixel counter and the `active` flag.
- ARM:
  - `lect`=0.
  - `vsync`=1 → CAPTURE.
  - Waits indefinitely; no timeout.
- CAPTURE:
  - `lect`=1.
  - Set internal `active` on the first cycle `vsync`=0.
  - `frame_done` is honoured only when `active`=1, so a stale flag from the front end is ignored.
  - `frame_done`&&`active` → DONE.
- DONE, lasts exactly one cycle:
  - `lect` stays 1 so the front end clears its `frame_done` while VSYNC is high.
  - `done`=1.
  - `frame_err` ← (count ≠ H_RES*V_RES).
  - Next state: ARM if `continuous`=1, else IDLE.
  - Counter and `active` cleared.
- Pixel path, active in CAPTURE only:
  - Each `pixel_valid` with count < H_RES*V_RES gives `mem_we`=1 next cycle.
  - `mem_data` = {pixel_data[15:13], pixel_data[10:8], pixel_data[4:3]}.
  - `mem_addr` = count; count increments.
- Counter:
  - Width ADDR_W+1.
  - Saturates at H_RES*V_RES+1. Pixels beyond H_RES*V_RES are dropped (no write) but still counted, so `frame_err` flags long frames.
  - Never wraps.
- Pixel strobes outside CAPTURE are ignored.
- `start` while `busy` is ignored.
- Deasserting `start` has no effect once armed. Only `continuous`=0 stops a running stream, and it stops at the next DONE.

## Timing
- Reset values: state IDLE; `lect`, `mem_we`, `busy`, `done`, `frame_err` = 0; `mem_addr`, `mem_data` = 0; counter 0; `active` 0.
- Reset mid-frame returns to IDLE immediately. The partially written buffer is not cleaned.
- `start` high in cycle N → `busy` high in N+1.
- `vsync` high in ARM at cycle N → `lect` high from N+1.
- Write latency: `pixel_valid` at N → `mem_we`, `mem_addr`, `mem_data` valid at N+1. Outputs are registered, with no combinational path from inputs.
- `pixel_valid` and `frame_done` in the same cycle: that pixel is written, and the DONE transition happens concurrently.
- `frame_done` at N → `done` pulse at N+1 → `lect` low at N+2 (single-shot) or re-armed.
- `frame_err` updates in the DONE cycle and holds until the next IDLE→ARM.
- Throughput: one write per `pixel_valid`. The front end produces at most one pixel per 2 clocks; back-to-back strobes must also work.

## Test plan
- Single shot, 4×2 (H_RES=4, V_RES=2): `start` pulse, `vsync` high 3 cycles, 8 valid pixels, then `vsync` high with `frame_done` → 8 writes at addr 0..7, one `done` pulse, `frame_err`=0, `busy` low 1 cycle after `done`.
- Pixel 16'hF81F → `mem_data`=8'hE3. Pixel 16'h07E0 → 8'h1C.
- `start` while `vsync`=0 mid-frame → `lect` stays 0 until `vsync` rises. `frame_done` held high at CAPTURE entry (before `vsync` falls) → no early `done`.
- 10 pixels into a 4×2 frame → exactly 8 writes (addr 0..7), `frame_err`=1. A 5-pixel frame → 5 writes, `frame_err`=1.
- `continuous`=1 for 3 frames → 3 `done` pulses, each frame's writes restart at addr 0. Drop `continuous` during frame 3 → IDLE after its `done`.
- Assert `rst` during pixel 3 → all outputs 0 in the same cycle, state IDLE. A new `start` captures a clean frame from addr 0.
